// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the memory (slave).
// Requests are held stable until dmem_ready is seen at a rising edge; read data is valid alongside ready.
interface dmem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store engine: issues one bus access per load/store and formats load data.
// Latency 3 cycles minimum (IDLE, REQ, DONE); stalls the pipeline until ready or timeout.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read_mem,
    input  logic                  mem_write_mem,
    input  logic [2:0]            funct3_mem,
    input  logic [31:0]           alu_result_mem,
    input  logic [31:0]           write_data_mem,
    dmem_access_unit_if.master    bus,
    output logic [31:0]           read_data_mem,
    output logic                  stall_mem,
    output logic                  misaligned,
    output logic                  bus_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    ld_funct3;
    logic [1:0]    ld_lane;

    logic          access;
    logic [1:0]    size;
    logic          addr_mis;
    logic          start;
    logic          ready_hit;
    logic          timeout;
    logic [31:0]   st_wdata;
    logic [3:0]    st_wstrb;
    logic [31:0]   rd_shift;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_fmt;

    // Size comes from funct3[1:0]; 11 and the unused load codes fall into word handling.
    assign access = mem_read_mem | mem_write_mem;
    assign size   = funct3_mem[1:0];

    always_comb begin
        addr_mis = 1'b0;
        case (size)
            2'b00:   addr_mis = 1'b0;
            2'b01:   addr_mis = alu_result_mem[0];
            default: addr_mis = |alu_result_mem[1:0];
        endcase
    end

    assign misaligned = (state == IDLE) & access & addr_mis;
    assign start      = (state == IDLE) & access & ~addr_mis;
    assign stall_mem  = start | (state == REQ);
    assign ready_hit  = (state == REQ) & bus.dmem_ready;
    assign timeout    = (state == REQ) & ~bus.dmem_ready & (wait_cnt == LAST_WAIT);

    always_comb begin
        st_wdata = write_data_mem;
        st_wstrb = 4'b1111;
        case (size)
            2'b00: begin
                st_wdata = {4{write_data_mem[7:0]}};
                st_wstrb = 4'b0001 << alu_result_mem[1:0];
            end
            2'b01: begin
                st_wdata = {2{write_data_mem[15:0]}};
                st_wstrb = alu_result_mem[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = write_data_mem;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Lane and funct3 are latched at issue so formatting does not depend on the held EX/MEM inputs.
    assign rd_shift = bus.dmem_rdata >> {ld_lane, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = ld_lane[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

    always_comb begin
        ld_fmt = bus.dmem_rdata;
        case (ld_funct3)
            3'b000:  ld_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_fmt = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_fmt = {24'h0, rd_byte};
            3'b101:  ld_fmt = {16'h0, rd_half};
            default: ld_fmt = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (ready_hit | timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= 32'h0;
            bus.dmem_wdata <= 32'h0;
            bus.dmem_wstrb <= 4'h0;
            read_data_mem  <= 32'h0;
            bus_error      <= 1'b0;
            wait_cnt       <= '0;
            ld_funct3      <= 3'b000;
            ld_lane        <= 2'b00;
        end else begin
            bus_error <= timeout;

            if (start) begin
                bus.dmem_req   <= 1'b1;
                bus.dmem_we    <= mem_write_mem;
                bus.dmem_addr  <= {alu_result_mem[31:2], 2'b00};
                bus.dmem_wdata <= st_wdata;
                bus.dmem_wstrb <= mem_write_mem ? st_wstrb : 4'b0000;
                ld_funct3      <= funct3_mem;
                ld_lane        <= alu_result_mem[1:0];
                wait_cnt       <= '0;
            end else if (misaligned) begin
                read_data_mem <= 32'h0;
            end

            // Ready on the last allowed wait cycle still completes normally.
            if (state == REQ) begin
                if (bus.dmem_ready) begin
                    bus.dmem_req   <= 1'b0;
                    bus.dmem_we    <= 1'b0;
                    bus.dmem_wstrb <= 4'h0;
                    if (!bus.dmem_we) begin
                        read_data_mem <= ld_fmt;
                    end
                end else if (timeout) begin
                    bus.dmem_req   <= 1'b0;
                    bus.dmem_we    <= 1'b0;
                    bus.dmem_wstrb <= 4'h0;
                    read_data_mem  <= 32'h0;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: a bus responder with programmable ready delay,
// expected completions queued at issue and compared when the access reaches DONE.
module tb_dmem_access_unit;

    localparam int TMO = 4;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          stalls;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] write_data_mem;
    logic [31:0] read_data_mem;
    logic        stall_mem;
    logic        misaligned;
    logic        bus_error;

    dmem_access_unit_if bus ();

    dmem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read_mem   (mem_read_mem),
        .mem_write_mem  (mem_write_mem),
        .funct3_mem     (funct3_mem),
        .alu_result_mem (alu_result_mem),
        .write_data_mem (write_data_mem),
        .bus            (bus),
        .read_data_mem  (read_data_mem),
        .stall_mem      (stall_mem),
        .misaligned     (misaligned),
        .bus_error      (bus_error)
    );

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [31:0] last_rd = 32'h0;
    logic [31:0] resp_word = 32'h0;
    int          resp_delay = 0;
    logic [2:0]  ld_codes[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: bus request, completion value, error and stall length of one access.
    task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rword, input int d,
                         output exp_t e, output bit mis);
        logic [1:0]  sz;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] fmt;
        bit          ok;
        sz  = f3[1:0];
        mis = (sz == 2'b00) ? 1'b0 : (sz == 2'b01) ? addr[0] : (addr[1:0] != 2'b00);
        e.we   = wr;
        e.addr = {addr[31:2], 2'b00};
        case (sz)
            2'b00:   begin e.wdata = {4{wd[7:0]}};  e.wstrb = 4'b0001 << addr[1:0]; end
            2'b01:   begin e.wdata = {2{wd[15:0]}}; e.wstrb = addr[1] ? 4'b1100 : 4'b0011; end
            default: begin e.wdata = wd;            e.wstrb = 4'b1111; end
        endcase
        if (!wr) e.wstrb = 4'b0000;
        ok       = (d + 1) <= TMO;
        e.err    = !ok;
        e.stalls = 1 + (ok ? d + 1 : TMO);
        b = rword[8*addr[1:0] +: 8];
        h = addr[1] ? rword[31:16] : rword[15:0];
        case (f3)
            3'b000:  fmt = {{24{b[7]}}, b};
            3'b001:  fmt = {{16{h[15]}}, h};
            3'b100:  fmt = {24'h0, b};
            3'b101:  fmt = {16'h0, h};
            default: fmt = rword;
        endcase
        if (mis || !ok) last_rd = 32'h0;
        else if (!wr)   last_rd = fmt;
        e.rd = last_rd;
    endtask

    task automatic idle_inputs();
        mem_read_mem   = 1'b0;
        mem_write_mem  = 1'b0;
        funct3_mem     = 3'b000;
        alu_result_mem = 32'h0;
        write_data_mem = 32'h0;
    endtask

    // Called just after a falling edge with the DUT in IDLE.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rword, input int d);
        exp_t e;
        bit   mis;
        int   sc;
        model(rd, wr, f3, addr, wd, rword, d, e, mis);
        mem_read_mem   = rd;
        mem_write_mem  = wr;
        funct3_mem     = f3;
        alu_result_mem = addr;
        write_data_mem = wd;
        resp_word      = rword;
        resp_delay     = d;
        if (!mis) exp_q.push_back(e);
        #1;
        check("misaligned", misaligned, mis);
        check("stall_idle", stall_mem, !mis);
        if (mis) begin
            @(negedge clk);
            check("mis_no_req", bus.dmem_req, 1'b0);
            check("mis_rdata", read_data_mem, 32'h0);
            idle_inputs();
            return;
        end
        sc = 1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.dmem_req) break;
            sc++;
            check("stall_req", stall_mem, 1'b1);
        end
        if (bus.dmem_req) begin
            check("done_bound", bus.dmem_req, 1'b0);
            $display("FAIL hang: access never completed");
            $fatal(1);
        end
        e = exp_q.pop_front();
        check("rdata_done", read_data_mem, e.rd);
        check("bus_error", bus_error, e.err);
        check("stall_done", stall_mem, 1'b0);
        check("stall_len", sc, e.stalls);
        idle_inputs();
        @(negedge clk);
        check("err_pulse", bus_error, 1'b0);
        check("rdata_hold", read_data_mem, e.rd);
    endtask

    // Memory responder: checks the held request every REQ cycle and raises ready after resp_delay cycles.
    initial begin
        int cnt;
        cnt = 0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (reset || !bus.dmem_req) begin
                cnt = 0;
                bus.dmem_ready = 1'b0;
                bus.dmem_rdata = 32'h0BAD0BAD;
            end else begin
                if (exp_q.size() > 0) begin
                    check("bus_addr", bus.dmem_addr, exp_q[0].addr);
                    check("bus_we", bus.dmem_we, exp_q[0].we);
                    check("bus_wstrb", bus.dmem_wstrb, exp_q[0].wstrb);
                    if (exp_q[0].we) check("bus_wdata", bus.dmem_wdata, exp_q[0].wdata);
                end
                bus.dmem_ready = (cnt == resp_delay);
                bus.dmem_rdata = bus.dmem_ready ? resp_word : 32'h0BAD0BAD;
                cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("rst_req", bus.dmem_req, 1'b0);
        check("rst_we", bus.dmem_we, 1'b0);
        check("rst_addr", bus.dmem_addr, 32'h0);
        check("rst_wdata", bus.dmem_wdata, 32'h0);
        check("rst_wstrb", bus.dmem_wstrb, 4'h0);
        check("rst_rdata", read_data_mem, 32'h0);
        check("rst_err", bus_error, 1'b0);
        check("rst_stall", stall_mem, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0);
        access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0);
        access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80123456, 1);
        access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0);
        access(1, 0, 3'b000, 32'h100, 32'h0, 32'h80123456, 2);
        access(0, 1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 1);
        access(0, 1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0);
        access(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, TMO - 1);
        access(1, 1, 3'b000, 32'h106, 32'h0000005A, 32'h0, 0);
        access(1, 0, 3'b010, 32'h102, 32'h0, 32'h11111111, 0);
        access(1, 0, 3'b001, 32'h101, 32'h0, 32'h11111111, 0);
        access(0, 1, 3'b010, 32'h103, 32'h12345678, 32'h0, 0);
        access(1, 0, 3'b010, 32'h108, 32'h0, 32'h55AA55AA, 0);
        access(1, 0, 3'b010, 32'h10C, 32'h0, 32'h77777777, 99);
        access(1, 0, 3'b011, 32'h110, 32'h0, 32'h87654321, 0);

        // Reset while the request is outstanding.
        mem_read_mem   = 1'b1;
        funct3_mem     = 3'b010;
        alu_result_mem = 32'h200;
        resp_delay     = 99;
        exp_q.push_back('{rd: 32'h0, err: 1'b0, we: 1'b0, addr: 32'h200,
                          wdata: 32'h0, wstrb: 4'h0, stalls: 0});
        @(negedge clk);
        check("pre_rst_req", bus.dmem_req, 1'b1);
        reset = 1'b1;
        idle_inputs();
        #1;
        check("midrst_req", bus.dmem_req, 1'b0);
        check("midrst_stall", stall_mem, 1'b0);
        check("midrst_rdata", read_data_mem, 32'h0);
        void'(exp_q.pop_front());
        last_rd = 32'h0;
        @(negedge clk);
        check("midrst_idle_req", bus.dmem_req, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        access(1, 0, 3'b010, 32'h204, 32'h0, 32'hA5A5F00F, 0);
        access(1, 0, 3'b001, 32'h206, 32'h0, 32'h7FFF8000, 0);

        for (int i = 0; i < 24; i++) begin
            logic        wr;
            logic [2:0]  f3;
            wr = ($urandom_range(0, 2) == 0);
            f3 = wr ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
            access(!wr, wr, f3, 32'h300 + 32'($urandom_range(0, 63)),
                   $urandom, $urandom, $urandom_range(0, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
